// File: rtl/hazard_redirect_ctrl_pkg.sv
// Shared pipeline definitions for the hazard/redirect controller.
package hazard_redirect_ctrl_pkg;

    localparam int REG_W = 5;
    localparam int PC_W  = 32;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        WAIT  = 2'd1,
        FLUSH = 2'd2
    } state_t;

endpackage

// File: rtl/hazard_redirect_ctrl_sat_counter.sv
// Saturating up-counter used for the stall/flush statistics.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         en,
    input  logic         clk,
    input  logic         rst_n,
    output logic [W-1:0] q
);

    // Count enabled cycles, holding at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (en && (q != '1)) begin
            q <= q + W'(1);
        end
    end

endmodule

// File: rtl/hazard_redirect_ctrl.sv
// Pipeline hazard / redirect controller: load-use stalls, memory-wait freeze,
// redirect flush sequencing and saturating statistics.
module hazard_redirect_ctrl
    import hazard_redirect_ctrl_pkg::*;
#(
    parameter int FLUSH_CYC = 1,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_redirect,
    input  logic [PC_W-1:0]  ex_target,
    input  logic             mem_busy,
    output logic             pc_en,
    output logic             pc_sel,
    output logic [PC_W-1:0]  redirect_pc,
    output logic             ifid_en,
    output logic             ifid_clr,
    output logic             idex_clr,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [1:0] FLUSH_RELOAD = 2'(FLUSH_CYC - 1);

    state_t          state, state_next;
    logic [1:0]      fcnt, fcnt_next;
    logic            pending, pending_next;
    logic [PC_W-1:0] pend_target, pend_target_next;

    logic load_use;
    logic take_pending;
    logic run_like;
    logic apply_redirect;

    assign load_use = ex_mem_read && (ex_rd != '0) &&
                      ((id_use_rs && (id_rs == ex_rd)) ||
                       (id_use_rt && (id_rt == ex_rd)));

    // The first non-busy WAIT cycle without a latched redirect behaves as RUN.
    assign take_pending   = (state == WAIT) && pending;
    assign run_like       = (state == RUN) || ((state == WAIT) && !pending);
    assign apply_redirect = !mem_busy && (take_pending || (run_like && ex_redirect));

    // State, flush countdown and latched-redirect registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RUN;
            fcnt        <= '0;
            pending     <= 1'b0;
            pend_target <= '0;
        end else begin
            state       <= state_next;
            fcnt        <= fcnt_next;
            pending     <= pending_next;
            pend_target <= pend_target_next;
        end
    end

    // Next-state: mem_busy beats redirect; redirects arriving while frozen are latched.
    always_comb begin
        state_next       = state;
        fcnt_next        = fcnt;
        pending_next     = pending;
        pend_target_next = pend_target;
        case (state)
            RUN, WAIT: begin
                if (mem_busy) begin
                    state_next = WAIT;
                    if (ex_redirect) begin
                        pending_next     = 1'b1;
                        pend_target_next = ex_target;
                    end
                end else if (apply_redirect) begin
                    pending_next = 1'b0;
                    if (FLUSH_CYC > 1) begin
                        state_next = FLUSH;
                        fcnt_next  = FLUSH_RELOAD;
                    end else begin
                        state_next = RUN;
                    end
                end else begin
                    state_next = RUN;
                end
            end
            FLUSH: begin
                if (mem_busy) begin
                    state_next = WAIT;
                end else begin
                    fcnt_next = fcnt - 2'd1;
                    if (fcnt == 2'd1) begin
                        state_next = RUN;
                    end
                end
            end
            default: state_next = RUN;
        endcase
    end

    // Pipeline control outputs for the current cycle.
    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        pc_sel      = 1'b0;
        redirect_pc = '0;
        ifid_clr    = 1'b0;
        idex_clr    = 1'b0;
        if (mem_busy) begin
            pc_en   = 1'b0;
            ifid_en = 1'b0;
        end else if (state == FLUSH) begin
            ifid_clr = 1'b1;
            idex_clr = 1'b1;
        end else if (apply_redirect) begin
            pc_sel      = 1'b1;
            redirect_pc = take_pending ? pend_target : ex_target;
            ifid_clr    = 1'b1;
            idex_clr    = 1'b1;
        end else if (load_use) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_clr = 1'b1;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .en    (!pc_en),
        .clk   (clk),
        .rst_n (rst_n),
        .q     (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .en    (apply_redirect),
        .clk   (clk),
        .rst_n (rst_n),
        .q     (flush_cnt)
    );

endmodule

// File: tb/tb_hazard_redirect_ctrl.sv
// Self-checking bench for hazard_redirect_ctrl: three parameterisations share
// one stimulus; directed scenarios plus a randomized run against a reference model.
module tb_hazard_redirect_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  id_rs = '0, id_rt = '0, ex_rd = '0;
    logic        id_use_rs = 1'b0, id_use_rt = 1'b0, ex_mem_read = 1'b0;
    logic        ex_redirect = 1'b0, mem_busy = 1'b0;
    logic [31:0] ex_target = '0;

    logic        pc_en_a[3], pc_sel_a[3], ifid_en_a[3], ifid_clr_a[3], idex_clr_a[3];
    logic [31:0] rpc_a[3];
    logic [15:0] stall_a[3], flush_a[3];
    logic [15:0] s0, f0, s1, f1;
    logic [3:0]  s2, f2;

    assign stall_a[0] = s0;
    assign flush_a[0] = f0;
    assign stall_a[1] = s1;
    assign flush_a[1] = f1;
    assign stall_a[2] = {12'h000, s2};
    assign flush_a[2] = {12'h000, f2};

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hazard_redirect_ctrl #(.FLUSH_CYC(1), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect), .ex_target(ex_target),
        .mem_busy(mem_busy), .pc_en(pc_en_a[0]), .pc_sel(pc_sel_a[0]),
        .redirect_pc(rpc_a[0]), .ifid_en(ifid_en_a[0]), .ifid_clr(ifid_clr_a[0]),
        .idex_clr(idex_clr_a[0]), .stall_cnt(s0), .flush_cnt(f0)
    );

    hazard_redirect_ctrl #(.FLUSH_CYC(3), .CNT_W(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect), .ex_target(ex_target),
        .mem_busy(mem_busy), .pc_en(pc_en_a[1]), .pc_sel(pc_sel_a[1]),
        .redirect_pc(rpc_a[1]), .ifid_en(ifid_en_a[1]), .ifid_clr(ifid_clr_a[1]),
        .idex_clr(idex_clr_a[1]), .stall_cnt(s1), .flush_cnt(f1)
    );

    hazard_redirect_ctrl #(.FLUSH_CYC(2), .CNT_W(4)) dut_c (
        .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect), .ex_target(ex_target),
        .mem_busy(mem_busy), .pc_en(pc_en_a[2]), .pc_sel(pc_sel_a[2]),
        .redirect_pc(rpc_a[2]), .ifid_en(ifid_en_a[2]), .ifid_clr(ifid_clr_a[2]),
        .idex_clr(idex_clr_a[2]), .stall_cnt(s2), .flush_cnt(f2)
    );

    // ---------------- reference model ----------------
    int          fc[3]   = '{1, 3, 2};
    int          cmax[3] = '{65535, 65535, 15};
    int          m_left[3], m_stall[3], m_flush[3];
    bit          m_wait[3], m_pend[3];
    logic [31:0] m_ptgt[3];
    bit          e_pc_en[3], e_ifid_en[3], e_pc_sel[3], e_ifc[3], e_idc[3], e_applied[3];
    logic [31:0] e_rpc[3];

    function automatic bit ref_load_use();
        return ex_mem_read && (ex_rd != 5'd0) &&
               ((id_use_rs && id_rs == ex_rd) || (id_use_rt && id_rt == ex_rd));
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_left[k] = 0; m_stall[k] = 0; m_flush[k] = 0;
            m_wait[k] = 0; m_pend[k] = 0; m_ptgt[k] = '0;
        end
    endtask

    task automatic model_expect();
        for (int k = 0; k < 3; k++) begin
            e_pc_en[k] = 1; e_ifid_en[k] = 1; e_pc_sel[k] = 0; e_rpc[k] = '0;
            e_ifc[k] = 0; e_idc[k] = 0; e_applied[k] = 0;
            if (mem_busy) begin
                e_pc_en[k] = 0; e_ifid_en[k] = 0;
            end else if (m_left[k] > 0) begin
                e_ifc[k] = 1; e_idc[k] = 1;
            end else if (m_wait[k] && m_pend[k]) begin
                e_pc_sel[k] = 1; e_rpc[k] = m_ptgt[k]; e_ifc[k] = 1; e_idc[k] = 1;
                e_applied[k] = 1;
            end else if (ex_redirect) begin
                e_pc_sel[k] = 1; e_rpc[k] = ex_target; e_ifc[k] = 1; e_idc[k] = 1;
                e_applied[k] = 1;
            end else if (ref_load_use()) begin
                e_pc_en[k] = 0; e_ifid_en[k] = 0; e_idc[k] = 1;
            end
        end
    endtask

    task automatic model_advance();
        for (int k = 0; k < 3; k++) begin
            if (m_left[k] > 0) begin
                if (mem_busy) begin
                    m_wait[k] = 1; m_left[k] = 0;
                end else begin
                    m_left[k]--;
                end
            end else if (mem_busy) begin
                m_wait[k] = 1;
                if (ex_redirect) begin
                    m_pend[k] = 1; m_ptgt[k] = ex_target;
                end
            end else begin
                m_wait[k] = 0;
                if (e_applied[k]) begin
                    m_pend[k] = 0; m_left[k] = fc[k] - 1;
                end
            end
            if (!e_pc_en[k] && m_stall[k] < cmax[k]) m_stall[k]++;
            if (e_applied[k] && m_flush[k] < cmax[k]) m_flush[k]++;
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic idle_inputs();
        id_rs = '0; id_rt = '0; ex_rd = '0; id_use_rs = 0; id_use_rt = 0;
        ex_mem_read = 0; ex_redirect = 0; mem_busy = 0; ex_target = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic settle();
        #3;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        settle();
        total++;
        if (pc_en_a[0] !== 1'b1 || ifid_en_a[0] !== 1'b1 || pc_sel_a[0] !== 1'b0 ||
            ifid_clr_a[0] !== 1'b0 || idex_clr_a[0] !== 1'b0 || rpc_a[0] !== 32'h0 ||
            stall_a[0] !== 16'h0 || flush_a[0] !== 16'h0) begin
            bad++;
            $display("FAIL reset_state got pc_en=%b ifid_en=%b sel=%b clr=%b/%b rpc=%h cnt=%0d/%0d want 1 1 0 0/0 0 0/0",
                     pc_en_a[0], ifid_en_a[0], pc_sel_a[0], ifid_clr_a[0], idex_clr_a[0],
                     rpc_a[0], stall_a[0], flush_a[0]);
        end
        cyc();
        ex_redirect = 1; ex_target = 32'h40;
        cyc();
        ex_redirect = 0;
        settle();
        total++;
        if (ifid_clr_a[1] !== 1'b1) begin
            bad++;
            $display("FAIL reset_preflush_clr got %b want 1", ifid_clr_a[1]);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (flush_a[1] !== 16'h0 || ifid_clr_a[1] !== 1'b0) begin
            bad++;
            $display("FAIL reset_async got flush=%0d clr=%b want 0 0", flush_a[1], ifid_clr_a[1]);
        end
        cyc();
        rst_n = 1'b1;
        cyc();
        settle();
        total++;
        if (pc_en_a[1] !== 1'b1 || ifid_en_a[1] !== 1'b1 || ifid_clr_a[1] !== 1'b0 ||
            idex_clr_a[1] !== 1'b0 || stall_a[1] !== 16'h0 || flush_a[1] !== 16'h0) begin
            bad++;
            $display("FAIL reset_midflush got pc_en=%b ifid_en=%b clr=%b/%b cnt=%0d/%0d want 1 1 0/0 0/0",
                     pc_en_a[1], ifid_en_a[1], ifid_clr_a[1], idex_clr_a[1], stall_a[1], flush_a[1]);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        ex_mem_read = 1; ex_rd = 5'd8; id_rs = 5'd8; id_use_rs = 1;
        settle();
        total++;
        if (pc_en_a[0] !== 1'b0 || ifid_en_a[0] !== 1'b0 || idex_clr_a[0] !== 1'b1 ||
            ifid_clr_a[0] !== 1'b0) begin
            bad++;
            $display("FAIL load_use_rs got pc_en=%b ifid_en=%b idex=%b ifid_clr=%b want 0 0 1 0",
                     pc_en_a[0], ifid_en_a[0], idex_clr_a[0], ifid_clr_a[0]);
        end
        cyc();
        ex_mem_read = 0;
        settle();
        total++;
        if (pc_en_a[0] !== 1'b1 || stall_a[0] !== 16'd1) begin
            bad++;
            $display("FAIL load_use_release got pc_en=%b stall=%0d want 1 1", pc_en_a[0], stall_a[0]);
        end
        ex_mem_read = 1; ex_rd = 5'd0; id_rs = 5'd0;
        settle();
        total++;
        if (pc_en_a[0] !== 1'b1 || idex_clr_a[0] !== 1'b0) begin
            bad++;
            $display("FAIL load_use_r0 got pc_en=%b idex=%b want 1 0", pc_en_a[0], idex_clr_a[0]);
        end
        id_use_rs = 0; id_use_rt = 1; id_rt = 5'd9; ex_rd = 5'd9; id_rs = 5'd9;
        settle();
        total++;
        if (pc_en_a[0] !== 1'b0 || idex_clr_a[0] !== 1'b1) begin
            bad++;
            $display("FAIL load_use_rt got pc_en=%b idex=%b want 0 1", pc_en_a[0], idex_clr_a[0]);
        end
        id_use_rt = 0;
        settle();
        total++;
        if (pc_en_a[0] !== 1'b1) begin
            bad++;
            $display("FAIL load_use_unused got pc_en=%b want 1", pc_en_a[0]);
        end
        cyc();
        total++;
        if (stall_a[0] !== 16'd1) begin
            bad++;
            $display("FAIL load_use_stallcnt got %0d want 1", stall_a[0]);
        end
    endtask

    task automatic test_redirect();
        do_reset();
        ex_redirect = 1; ex_target = 32'h0000_0040;
        settle();
        total++;
        if (pc_sel_a[0] !== 1'b1 || rpc_a[0] !== 32'h40 || ifid_clr_a[0] !== 1'b1 ||
            idex_clr_a[0] !== 1'b1 || pc_en_a[0] !== 1'b1) begin
            bad++;
            $display("FAIL redirect got sel=%b rpc=%h clr=%b/%b pc_en=%b want 1 00000040 1/1 1",
                     pc_sel_a[0], rpc_a[0], ifid_clr_a[0], idex_clr_a[0], pc_en_a[0]);
        end
        cyc();
        ex_redirect = 0;
        settle();
        total++;
        if (flush_a[0] !== 16'd1 || pc_sel_a[0] !== 1'b0 || ifid_clr_a[0] !== 1'b0) begin
            bad++;
            $display("FAIL redirect_after got flush=%0d sel=%b clr=%b want 1 0 0",
                     flush_a[0], pc_sel_a[0], ifid_clr_a[0]);
        end
    endtask

    task automatic test_mem_wait();
        do_reset();
        mem_busy = 1; ex_redirect = 1; ex_target = 32'h80;
        for (int i = 0; i < 3; i++) begin
            settle();
            total++;
            if (pc_en_a[0] !== 1'b0 || ifid_en_a[0] !== 1'b0 || pc_sel_a[0] !== 1'b0 ||
                ifid_clr_a[0] !== 1'b0 || idex_clr_a[0] !== 1'b0) begin
                bad++;
                $display("FAIL wait_frozen cyc%0d got pc_en=%b ifid_en=%b sel=%b clr=%b/%b want 0 0 0 0/0",
                         i, pc_en_a[0], ifid_en_a[0], pc_sel_a[0], ifid_clr_a[0], idex_clr_a[0]);
            end
            cyc();
            ex_redirect = 0;
        end
        mem_busy = 0;
        settle();
        total++;
        if (pc_sel_a[0] !== 1'b1 || rpc_a[0] !== 32'h80 || ifid_clr_a[0] !== 1'b1 ||
            stall_a[0] !== 16'd3) begin
            bad++;
            $display("FAIL wait_pending got sel=%b rpc=%h clr=%b stall=%0d want 1 00000080 1 3",
                     pc_sel_a[0], rpc_a[0], ifid_clr_a[0], stall_a[0]);
        end
        cyc();
        settle();
        total++;
        if (pc_sel_a[0] !== 1'b0 || flush_a[0] !== 16'd1) begin
            bad++;
            $display("FAIL wait_after got sel=%b flush=%0d want 0 1", pc_sel_a[0], flush_a[0]);
        end
    endtask

    task automatic test_flush_multi();
        do_reset();
        ex_redirect = 1; ex_target = 32'h100;
        for (int i = 0; i < 4; i++) begin
            settle();
            total++;
            if (ifid_clr_a[1] !== (i < 3) || pc_sel_a[1] !== (i == 0) || pc_en_a[1] !== 1'b1) begin
                bad++;
                $display("FAIL flush3 cyc%0d got clr=%b sel=%b pc_en=%b want %b %b 1",
                         i, ifid_clr_a[1], pc_sel_a[1], pc_en_a[1], i < 3, i == 0);
            end
            total++;
            if (ifid_clr_a[2] !== (i < 2)) begin
                bad++;
                $display("FAIL flush2 cyc%0d got clr=%b want %b", i, ifid_clr_a[2], i < 2);
            end
            cyc();
            ex_redirect = (i == 0);
            ex_target   = 32'h200;
        end
        total++;
        if (flush_a[1] !== 16'd1 || flush_a[2] !== 16'd1) begin
            bad++;
            $display("FAIL flush_count got %0d/%0d want 1/1", flush_a[1], flush_a[2]);
        end
    endtask

    task automatic test_flush_busy();
        do_reset();
        ex_redirect = 1; ex_target = 32'h300;
        cyc();
        ex_redirect = 0; mem_busy = 1;
        settle();
        total++;
        if (pc_en_a[1] !== 1'b0 || ifid_clr_a[1] !== 1'b0) begin
            bad++;
            $display("FAIL flush_busy got pc_en=%b clr=%b want 0 0", pc_en_a[1], ifid_clr_a[1]);
        end
        cyc();
        mem_busy = 0;
        settle();
        total++;
        if (pc_en_a[1] !== 1'b1 || ifid_clr_a[1] !== 1'b0 || pc_sel_a[1] !== 1'b0) begin
            bad++;
            $display("FAIL flush_dropped got pc_en=%b clr=%b sel=%b want 1 0 0",
                     pc_en_a[1], ifid_clr_a[1], pc_sel_a[1]);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        mem_busy = 1;
        repeat (20) cyc();
        mem_busy = 0;
        settle();
        total++;
        if (stall_a[2] !== 16'h000F || stall_a[0] !== 16'd20) begin
            bad++;
            $display("FAIL saturate got c=%h a=%0d want f 20", stall_a[2], stall_a[0]);
        end
    endtask

    task automatic test_random();
        do_reset();
        model_reset();
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
                model_reset();
            end
            id_rs       = 5'($urandom_range(0, 3));
            id_rt       = 5'($urandom_range(0, 3));
            ex_rd       = 5'($urandom_range(0, 3));
            id_use_rs   = $urandom_range(0, 1) == 1;
            id_use_rt   = $urandom_range(0, 1) == 1;
            ex_mem_read = $urandom_range(0, 2) == 0;
            mem_busy    = $urandom_range(0, 3) == 0;
            ex_redirect = $urandom_range(0, 6) == 0;
            ex_target   = $urandom;
            settle();
            model_expect();
            for (int k = 0; k < 3; k++) begin
                total++;
                if (pc_en_a[k] !== e_pc_en[k] || ifid_en_a[k] !== e_ifid_en[k]) begin
                    bad++;
                    $display("FAIL rnd_en dut%0d n%0d got %b%b want %b%b",
                             k, n, pc_en_a[k], ifid_en_a[k], e_pc_en[k], e_ifid_en[k]);
                end
                total++;
                if (pc_sel_a[k] !== e_pc_sel[k] || rpc_a[k] !== e_rpc[k]) begin
                    bad++;
                    $display("FAIL rnd_sel dut%0d n%0d got %b %h want %b %h",
                             k, n, pc_sel_a[k], rpc_a[k], e_pc_sel[k], e_rpc[k]);
                end
                total++;
                if (ifid_clr_a[k] !== e_ifc[k] || idex_clr_a[k] !== e_idc[k]) begin
                    bad++;
                    $display("FAIL rnd_clr dut%0d n%0d got %b%b want %b%b",
                             k, n, ifid_clr_a[k], idex_clr_a[k], e_ifc[k], e_idc[k]);
                end
                total++;
                if (stall_a[k] !== 16'(m_stall[k]) || flush_a[k] !== 16'(m_flush[k])) begin
                    bad++;
                    $display("FAIL rnd_cnt dut%0d n%0d got %0d/%0d want %0d/%0d",
                             k, n, stall_a[k], flush_a[k], m_stall[k], m_flush[k]);
                end
            end
            @(posedge clk);
            model_advance();
            #1;
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_load_use();
        test_redirect();
        test_mem_wait();
        test_flush_multi();
        test_flush_busy();
        test_saturate();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
